// File: rtl/tx_interpolator.sv
// Transmit CIC interpolator: host-rate I/Q in, full-rate I/Q out, with PTT gating, drain and underflow flag.
// Optional macro TX_UNDERFLOW_HOLD_EN re-enters the last consumed sample on an underflow tick instead of zero.
module tx_interpolator #(
  parameter int INTERP    = 1280,
  parameter int STAGES    = 3,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 37,
  parameter int OUT_WIDTH = 18
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        enable_i,
  output logic                        in_req_o,
  input  logic                        in_valid_i,
  input  logic signed [IN_WIDTH-1:0]  in_I_i,
  input  logic signed [IN_WIDTH-1:0]  in_Q_i,
  output logic                        out_strobe_o,
  output logic signed [OUT_WIDTH-1:0] out_I_o,
  output logic signed [OUT_WIDTH-1:0] out_Q_o,
  output logic                        active_o,
  output logic                        underflow_o,
  input  logic                        underflow_clr_i
);

  localparam int CW = $clog2(INTERP);
  localparam int DW = $clog2(STAGES * INTERP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DW-1:0]               drain_q, drain_d;
  logic                        full_q, full_d;
  logic signed [IN_WIDTH-1:0]  holdI_q, holdI_d, holdQ_q, holdQ_d;
  logic                        uf_q, uf_d;
  logic signed [IN_WIDTH-1:0]  selI, selQ;
  logic                        clearAll, active, tick;
`ifdef TX_UNDERFLOW_HOLD_EN
  logic signed [IN_WIDTH-1:0]  lastI_q, lastI_d, lastQ_q, lastQ_d;
`endif

  logic signed [ACC_WIDTH-1:0] sample   [2];
  logic signed [ACC_WIDTH-1:0] combDly_q [2][STAGES];
  logic signed [ACC_WIDTH-1:0] combDly_d [2][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_q   [2];
  logic signed [ACC_WIDTH-1:0] comb_d   [2];
  logic signed [ACC_WIDTH-1:0] integ_q  [2][STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d  [2][STAGES];
  logic                        stuff_q, stuff_d;

  assign active       = (state_q != IDLE);
  assign tick         = active && (cnt_q == CW'(INTERP - 1));
  assign in_req_o     = (state_q == RUN) && (cnt_q == '0);
  assign active_o     = active;
  assign out_strobe_o = active;
  assign underflow_o  = uf_q;
  assign out_I_o      = integ_q[0][STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH];
  assign out_Q_o      = integ_q[1][STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH];
  assign sample[0]    = {{(ACC_WIDTH-IN_WIDTH){selI[IN_WIDTH-1]}}, selI};
  assign sample[1]    = {{(ACC_WIDTH-IN_WIDTH){selQ[IN_WIDTH-1]}}, selQ};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    full_d   = full_q;
    holdI_d  = holdI_q;
    holdQ_d  = holdQ_q;
    uf_d     = uf_q;
    selI     = '0;
    selQ     = '0;
    clearAll = 1'b0;
`ifdef TX_UNDERFLOW_HOLD_EN
    lastI_d  = lastI_q;
    lastQ_d  = lastQ_q;
`endif
    if (active) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (underflow_clr_i) uf_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // A strobe landing on the tick itself is consumed directly, never parked.
        if (tick) begin
          full_d = 1'b0;
          if (in_valid_i) begin
            selI = in_I_i;
            selQ = in_Q_i;
          end else if (full_q) begin
            selI = holdI_q;
            selQ = holdQ_q;
          end else begin
            uf_d = 1'b1;
`ifdef TX_UNDERFLOW_HOLD_EN
            selI = lastI_q;
            selQ = lastQ_q;
`endif
          end
`ifdef TX_UNDERFLOW_HOLD_EN
          lastI_d = selI;
          lastQ_d = selQ;
`endif
        end else if (in_valid_i) begin
          full_d  = 1'b1;
          holdI_d = in_I_i;
          holdQ_d = in_Q_i;
        end
        if (!enable_i) begin
          state_d = DRAIN;
          drain_d = DW'(STAGES * INTERP);
        end
      end
      DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (enable_i) begin
          state_d = RUN;
        end else if (drain_q == DW'(1)) begin
          state_d  = IDLE;
          clearAll = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clearAll) begin
      cnt_d   = '0;
      full_d  = 1'b0;
      holdI_d = '0;
      holdQ_d = '0;
`ifdef TX_UNDERFLOW_HOLD_EN
      lastI_d = '0;
      lastQ_d = '0;
`endif
    end
  end

  // Combs run at the tick rate; integrators see the comb result for exactly one cycle (zero-stuffing).
  always_comb begin
    logic signed [ACC_WIDTH-1:0] stage;
    stage = '0;
    for (int c = 0; c < 2; c++) begin
      stage = sample[c];
      for (int k = 0; k < STAGES; k++) begin
        combDly_d[c][k] = clearAll ? '0 : (tick ? stage : combDly_q[c][k]);
        stage = stage - combDly_q[c][k];
      end
      comb_d[c] = clearAll ? '0 : (tick ? stage : comb_q[c]);
      integ_d[c][0] = clearAll ? '0 :
                      (active ? integ_q[c][0] + (stuff_q ? comb_q[c] : '0) : integ_q[c][0]);
      for (int k = 1; k < STAGES; k++) begin
        integ_d[c][k] = clearAll ? '0 :
                        (active ? integ_q[c][k] + integ_q[c][k-1] : integ_q[c][k]);
      end
    end
    stuff_d = tick && !clearAll;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      full_q    <= 1'b0;
      holdI_q   <= '0;
      holdQ_q   <= '0;
      uf_q      <= 1'b0;
      combDly_q <= '{default: '0};
      comb_q    <= '{default: '0};
      integ_q   <= '{default: '0};
      stuff_q   <= 1'b0;
`ifdef TX_UNDERFLOW_HOLD_EN
      lastI_q   <= '0;
      lastQ_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      full_q    <= full_d;
      holdI_q   <= holdI_d;
      holdQ_q   <= holdQ_d;
      uf_q      <= uf_d;
      combDly_q <= combDly_d;
      comb_q    <= comb_d;
      integ_q   <= integ_d;
      stuff_q   <= stuff_d;
`ifdef TX_UNDERFLOW_HOLD_EN
      lastI_q   <= lastI_d;
      lastQ_q   <= lastQ_d;
`endif
    end
  end

endmodule

// File: doc/tx_interpolator.md
Name: tx_interpolator

Overview:
- Transmit-side counterpart of the receive decimation chain.
- Accepts baseband I/Q samples at the host sample rate (48 kHz) through a request/valid handshake and raises them to the full clock rate (61.44 MHz) with an N-stage CIC interpolator.
- Outputs go to the transmit CORDIC upconverter and then to the DAC path.
- Also handles PTT gating, graceful drain to zero after PTT release, and underflow detection.

Parameters:
- INTERP, 1280: interpolation ratio R; one input sample per INTERP clocks; legal range 4..4095.
- STAGES, 3: CIC order N; legal range 2..5.
- IN_WIDTH, 16: input I/Q width, signed.
- ACC_WIDTH, 37: width of every comb/integrator register; must be ≥ IN_WIDTH + ceil(log2(R^(N-1))).
- OUT_WIDTH, 18: output width, signed; must be ≤ ACC_WIDTH.

Ports:
- clock  in  1  61.44 MHz system clock.
- reset_n  in  1  Asynchronous, active-low reset.
- enable  in  1  PTT; high = transmit.
- in_req  out  1  One-cycle pulse requesting the next input sample.
- in_valid  in  1  Qualifies in_I/in_Q; one-cycle strobe.
- in_I  in  IN_WIDTH  Baseband I, signed.
- in_Q  in  IN_WIDTH  Baseband Q, signed.
- out_strobe  out  1  High every cycle the output is valid.
- out_I  out  OUT_WIDTH  Interpolated I, signed.
- out_Q  out  OUT_WIDTH  Interpolated Q, signed.
- active  out  1  High in RUN or DRAIN.
- underflow  out  1  Sticky underflow flag.
- underflow_clr  in  1  Synchronous clear for underflow.

Behaviour:
- Reset: state IDLE; all comb, integrator, holding and counter registers = 0. in_req=0, out_strobe=0, out_I=out_Q=0, active=0, underflow=0.
- Phase counter runs 0..INTERP-1 and wraps; it runs only in RUN and DRAIN. A tick occurs at count INTERP-1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: on enable=1. Counter loads 0, and in_req pulses in the first RUN cycle.
  - RUN -> DRAIN: on enable=0. Draw-down counter loads STAGES*INTERP.
  - DRAIN -> RUN: on enable=1. Pipeline is kept, no clear.
  - DRAIN -> IDLE: when the draw-down counter reaches 0. All datapath registers are cleared on entry to IDLE.
- Handshake:
  - In RUN, in_req pulses at count 0.
  - One holding register pair plus a full flag. in_valid while not full captures the sample and sets full.
  - in_valid while full overwrites the held sample. No stall.
  - in_valid in IDLE or DRAIN is ignored.
- Tick in RUN:
  - If full: the held sample enters the comb chain and full clears.
  - If not full: zero enters the comb chain and underflow sets.
  - If in_valid arrives in the tick cycle itself, it is used directly and counts as present.
- Tick in DRAIN: zero enters the comb chain. No in_req is issued.
- Comb section:
  - STAGES cascaded first differences, updated only on a tick.
  - Combinational chain into a single registered comb output (cycle T+1 after tick cycle T).
- Zero-stuffing: the integrator-1 input equals the comb output in cycle T+1 only, and 0 in every other cycle.
- Integrators: STAGES registered accumulators, updated every cycle in RUN/DRAIN.
- Arithmetic: all registers ACC_WIDTH, two's-complement, modular wrap (no saturation needed).
- Output: out_I/out_Q = top OUT_WIDTH bits of the last integrator, truncated. DC gain = R^(N-1) / 2^(ACC_WIDTH-OUT_WIDTH).
- Latency: a sample consumed at tick cycle T first affects out_I/out_Q in cycle T+STAGES+1.
- out_strobe = active, registered in step with the output.
- Simultaneous underflow set and underflow_clr: set wins.
- reset_n asserted mid-operation: immediate return to the reset values, regardless of state.

Optional Feature:
- Macro: TX_UNDERFLOW_HOLD_EN.
- Defined: on an underflow tick in RUN, the previously consumed sample is re-entered into the comb chain instead of zero; underflow still sets.
- Undefined: zero is inserted.
- DRAIN always inserts zero in both cases.

Test Plan:
Bench parameters for all scenarios: INTERP=8, STAGES=3, IN_WIDTH=16, ACC_WIDTH=OUT_WIDTH=22.
1. Impulse: enable=1, answer the first in_req with I=1 and the rest with 0 -> out_I from latency point = 1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1, then 0. Q stays 0.
2. DC step: I=100, Q=-100 on every in_req -> steady state out_I=6400, out_Q=-6400. in_req exactly every 8 cycles.
3. Underflow: skip one answer in scenario 2 -> underflow=1 at that tick; underflow_clr clears it. With TX_UNDERFLOW_HOLD_EN, out_I stays 6400 throughout.
4. PTT release: from the DC steady state, drop enable -> output decays to exactly 0 within 24 cycles. active=0 after DRAIN. No in_req issued after the drop.
5. Re-key in DRAIN: enable 0 for 5 cycles, then 1 -> state RUN, no register clear, in_req resumes at the next count 0.
6. Async reset mid-RUN: assert reset_n=0 mid-RUN -> out_I=out_Q=0, out_strobe=0, underflow=0 without a clock edge.
